// File: rtl/ras_ckpt.sv
// ras_ckpt -- return address stack with tagged speculation checkpoints.
//
// Purpose:
//   Predicts return targets for the fetch-stage branch predictor from a
//   circular stack that overwrites its oldest entry on overflow. Every
//   predicted branch may take a checkpoint of the stack pointer and entry
//   count. A flush restores the state captured by any outstanding checkpoint
//   and discards that checkpoint and all younger ones.
//
// Configuration macro:
//   RAS_TOS_REPAIR_EN - when defined, each checkpoint also saves the TOS
//                       entry. A valid flush writes it back so that a
//                       wrong-path pop+push cannot leave a corrupted TOS.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   push       in   call: store push_pc
//   push_pc    in   return address to store (low ALIGN_BITS dropped)
//   pop        in   return: remove TOS
//   ckpt_take  in   allocate a checkpoint for a predicted branch
//   ckpt_id    out  id handed to a ckpt_take in this cycle
//   ckpt_full  out  all checkpoint slots occupied
//   resolve    in   oldest checkpoint resolved correctly; release it
//   flush      in   misprediction: restore checkpoint flush_id
//   flush_id   in   checkpoint to restore
//   pc_out     out  predicted return address, zero when the stack is empty
//   count      out  valid entries, 0..SIZE
//   is_empty   out  count == 0
//   is_full    out  count == SIZE
//
// SIZE and CKPT_DEPTH must be powers of two >= 2; ALIGN_BITS must be >= 1.

module ras_ckpt #(
  parameter int PC_BITS    = 32,
  parameter int SIZE       = 16,
  parameter int ALIGN_BITS = 1,
  parameter int CKPT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [PC_BITS-1:0]            push_pc,
  input  logic                          pop,
  input  logic                          ckpt_take,
  output logic [$clog2(CKPT_DEPTH)-1:0] ckpt_id,
  output logic                          ckpt_full,
  input  logic                          resolve,
  input  logic                          flush,
  input  logic [$clog2(CKPT_DEPTH)-1:0] flush_id,
  output logic [PC_BITS-1:0]            pc_out,
  output logic [$clog2(SIZE):0]         count,
  output logic                          is_empty,
  output logic                          is_full
);

  localparam int HW = $clog2(SIZE);
  localparam int CW = HW + 1;
  localparam int IW = $clog2(CKPT_DEPTH);
  localparam int OW = IW + 1;
  localparam int EW = PC_BITS - ALIGN_BITS;

  // Control state
  logic [HW-1:0] head_q, head_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] alloc_q, alloc_d;
  logic [IW-1:0] rel_q, rel_d;
  logic [OW-1:0] occ_q, occ_d;

  // Storage (not reset)
  logic [EW-1:0] stk_q        [SIZE];
  logic [HW-1:0] slot_head_q  [CKPT_DEPTH];
  logic [CW-1:0] slot_count_q [CKPT_DEPTH];
`ifdef RAS_TOS_REPAIR_EN
  logic [EW-1:0] slot_tos_q   [CKPT_DEPTH];
`endif

  logic [HW-1:0] tos_idx;
  logic [IW-1:0] flush_dist;
  logic          flush_ok;
  logic          take_ok;
  logic          rel_ok;
  logic          wr_en;
  logic [HW-1:0] wr_idx;
  logic [EW-1:0] wr_data;

  // The alignment bits are always zero on output and are never stored.
  logic unused_align;
  assign unused_align = ^push_pc[ALIGN_BITS-1:0];

  assign tos_idx   = head_q - HW'(1);
  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CW'(SIZE));
  assign count     = count_q;
  assign ckpt_full = (occ_q == OW'(CKPT_DEPTH));
  assign ckpt_id   = alloc_q;
  assign pc_out    = is_empty ? '0 : (PC_BITS'(stk_q[tos_idx]) << ALIGN_BITS);

  // A checkpoint id is live when its distance from the oldest slot is
  // inside the occupied window of the circular queue.
  assign flush_dist = flush_id - rel_q;
  assign flush_ok   = ({1'b0, flush_dist} < occ_q);

  // Full/empty checks use this cycle's occupancy, so a take on a full
  // queue is dropped even when a resolve frees a slot in the same cycle.
  assign take_ok = ckpt_take && !ckpt_full && !flush;
  assign rel_ok  = resolve && (occ_q != '0) && !flush;

  // Stack next state and storage write port
  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = head_q;
    wr_data = push_pc[PC_BITS-1:ALIGN_BITS];
    if (flush) begin
      if (flush_ok) begin
        head_d  = slot_head_q[flush_id];
        count_d = slot_count_q[flush_id];
`ifdef RAS_TOS_REPAIR_EN
        if (slot_count_q[flush_id] != '0) begin
          wr_en   = 1'b1;
          wr_idx  = slot_head_q[flush_id] - HW'(1);
          wr_data = slot_tos_q[flush_id];
        end
`endif
      end
    end else if (push && pop && !is_empty) begin
      // Return followed by call: replace TOS in place.
      wr_en  = 1'b1;
      wr_idx = tos_idx;
    end else if (push) begin
      // On overflow the write lands on the oldest entry; count saturates.
      wr_en  = 1'b1;
      head_d = head_q + HW'(1);
      if (!is_full) begin
        count_d = count_q + CW'(1);
      end
    end else if (pop && !is_empty) begin
      head_d  = head_q - HW'(1);
      count_d = count_q - CW'(1);
    end
  end

  // Checkpoint queue next state
  always_comb begin
    alloc_d = alloc_q;
    rel_d   = rel_q;
    occ_d   = occ_q;
    if (flush) begin
      if (flush_ok) begin
        // Keep only checkpoints older than the restored one.
        alloc_d = flush_id;
        occ_d   = OW'(flush_dist);
      end else begin
        alloc_d = rel_q;
        occ_d   = '0;
      end
    end else begin
      alloc_d = alloc_q + IW'(take_ok);
      rel_d   = rel_q + IW'(rel_ok);
      occ_d   = occ_q + OW'(take_ok) - OW'(rel_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      rel_q   <= '0;
      occ_q   <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      alloc_q <= alloc_d;
      rel_q   <= rel_d;
      occ_q   <= occ_d;
    end
  end

  // Checkpoints capture the pre-update stack state of the take cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stk_q[wr_idx] <= wr_data;
    end
    if (take_ok) begin
      slot_head_q[alloc_q]  <= head_q;
      slot_count_q[alloc_q] <= count_q;
`ifdef RAS_TOS_REPAIR_EN
      slot_tos_q[alloc_q]   <= stk_q[tos_idx];
`endif
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Testbench for ras_ckpt: directed scenarios plus randomized traffic checked
// against a behavioural model (circular array plus a queue of checkpoints).
module tb_ras_ckpt;

  localparam int PCB = 32;
  localparam int S   = 4;
  localparam int AB  = 1;
  localparam int D   = 4;
  localparam int IW  = $clog2(D);
  localparam int CW  = $clog2(S) + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            push = 1'b0;
  logic [PCB-1:0]  push_pc = '0;
  logic            pop = 1'b0;
  logic            ckpt_take = 1'b0;
  logic [IW-1:0]   ckpt_id;
  logic            ckpt_full;
  logic            resolve = 1'b0;
  logic            flush = 1'b0;
  logic [IW-1:0]   flush_id = '0;
  logic [PCB-1:0]  pc_out;
  logic [CW-1:0]   count;
  logic            is_empty;
  logic            is_full;

  ras_ckpt #(.PC_BITS(PCB), .SIZE(S), .ALIGN_BITS(AB), .CKPT_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_pc(push_pc), .pop(pop),
    .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .resolve(resolve), .flush(flush), .flush_id(flush_id),
    .pc_out(pc_out), .count(count), .is_empty(is_empty), .is_full(is_full)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          h;
    int          c;
    logic [31:0] t;
  } ck_t;

  logic [31:0] mem [S];
  int  m_head, m_count, m_alloc, m_rel;
  ck_t ckq [$];

  function automatic logic [31:0] m_pc();
    return (m_count == 0) ? 32'h0 : mem[(m_head + S - 1) % S];
  endfunction

  task automatic m_reset();
    m_head = 0; m_count = 0; m_alloc = 0; m_rel = 0;
    ckq.delete();
  endtask

  task automatic m_step(input bit p, input logic [31:0] pc, input bit po,
                        input bit tk, input bit rs, input bit fl, input int fid);
    logic [31:0] pcm;
    int k, n;
    ck_t e;
    pcm = pc & ~32'((1 << AB) - 1);
    if (fl) begin
      k = (fid - m_rel + D) % D;
      if (k < ckq.size()) begin
        e = ckq[k];
        m_head = e.h; m_count = e.c;
`ifdef RAS_TOS_REPAIR_EN
        if (m_count > 0) mem[(m_head + S - 1) % S] = e.t;
`endif
        while (ckq.size() > k) void'(ckq.pop_back());
        m_alloc = fid;
      end else begin
        ckq.delete();
        m_alloc = m_rel;
      end
    end else begin
      n = ckq.size();
      if (tk && n < D) begin
        e.h = m_head; e.c = m_count; e.t = mem[(m_head + S - 1) % S];
        ckq.push_back(e);
        m_alloc = (m_alloc + 1) % D;
      end
      if (rs && n > 0) begin
        void'(ckq.pop_front());
        m_rel = (m_rel + 1) % D;
      end
      if (p && po && m_count > 0) begin
        mem[(m_head + S - 1) % S] = pcm;
      end else if (p) begin
        mem[m_head] = pcm;
        m_head = (m_head + 1) % S;
        if (m_count < S) m_count++;
      end else if (po && m_count > 0) begin
        m_head = (m_head + S - 1) % S;
        m_count--;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_pc"},    pc_out,            m_pc());
    chk({tag, "_cnt"},   32'(count),        32'(m_count));
    chk({tag, "_empty"}, 32'(is_empty),     32'(m_count == 0));
    chk({tag, "_full"},  32'(is_full),      32'(m_count == S));
    chk({tag, "_cfull"}, 32'(ckpt_full),    32'(ckq.size() == D));
    chk({tag, "_cid"},   32'(ckpt_id),      32'(m_alloc));
  endtask

  // One clock with the given inputs; inputs change #1 after the edge.
  task automatic cyc(input string tag, input bit p, input logic [31:0] pc, input bit po,
                     input bit tk, input bit rs, input bit fl, input int fid);
    push = p; push_pc = pc; pop = po; ckpt_take = tk; resolve = rs;
    flush = fl; flush_id = IW'(fid);
    @(posedge clk);
    m_step(p, pc, po, tk, rs, fl, fid);
    #1;
    check_all(tag);
  endtask

  task automatic do_push(input logic [31:0] pc); cyc("push", 1, pc, 0, 0, 0, 0, 0); endtask
  task automatic do_pop();                       cyc("pop", 0, 0, 1, 0, 0, 0, 0);   endtask
  task automatic do_take();                      cyc("take", 0, 0, 0, 1, 0, 0, 0);  endtask
  task automatic do_flush(input int fid);        cyc("flush", 0, 0, 0, 0, 0, 1, fid); endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    push = 0; pop = 0; ckpt_take = 0; resolve = 0; flush = 0;
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_cnt"},   32'(count),     32'd0);
    chk({tag, "_rst_pc"},    pc_out,         32'd0);
    chk({tag, "_rst_empty"}, 32'(is_empty),  32'd1);
    chk({tag, "_rst_full"},  32'(is_full),   32'd0);
    chk({tag, "_rst_cfull"}, 32'(ckpt_full), 32'd0);
    chk({tag, "_rst_cid"},   32'(ckpt_id),   32'd0);
    m_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < S; i++) mem[i] = 32'h0;
    m_reset();
    @(posedge clk); #1;
    do_reset("init");

    // Basic push/pop and underflow
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    chk("t1_pc3", pc_out, 32'h300);
    chk("t1_cnt3", 32'(count), 32'd3);
    do_pop();  chk("t1_pop1", pc_out, 32'h200);
    do_pop();  chk("t1_pop2", pc_out, 32'h100);
    do_pop();  chk("t1_pop3", pc_out, 32'h0);
    chk("t1_empty", 32'(is_empty), 32'd1);
    do_pop();  chk("t1_under", 32'(count), 32'd0);

    // Overflow overwrites the oldest entry
    do_push(32'h10); do_push(32'h20); do_push(32'h30); do_push(32'h40); do_push(32'h50);
    chk("t2_full", 32'(is_full), 32'd1);
    chk("t2_cnt", 32'(count), 32'd4);
    chk("t2_tos", pc_out, 32'h50);
    do_pop(); chk("t2_p1", pc_out, 32'h40);
    do_pop(); chk("t2_p2", pc_out, 32'h30);
    do_pop(); chk("t2_p3", pc_out, 32'h20);
    do_pop(); chk("t2_empty", 32'(is_empty), 32'd1);

    // Same-cycle push+pop; alignment bit dropped
    do_push(32'h100); do_push(32'h201);
    chk("t3_align", pc_out, 32'h200);
    cyc("pp", 1, 32'h400, 1, 0, 0, 0, 0);
    chk("t3_pp_pc", pc_out, 32'h400);
    chk("t3_pp_cnt", 32'(count), 32'd2);
    do_pop(); do_pop();
    cyc("pp0", 1, 32'h80, 1, 0, 0, 0, 0);
    chk("t3_pp0_cnt", 32'(count), 32'd1);
    chk("t3_pp0_pc", pc_out, 32'h80);
    do_pop();

    // Nested checkpoints and flush
    do_push(32'h100);
    chk("t4_id0", 32'(ckpt_id), 32'd0);
    do_take();
    do_push(32'h200);
    chk("t4_id1", 32'(ckpt_id), 32'd1);
    do_take();
    do_push(32'h300);
    do_flush(1);
    chk("t4_f1_pc", pc_out, 32'h200);
    chk("t4_f1_cnt", 32'(count), 32'd2);
    chk("t4_f1_id", 32'(ckpt_id), 32'd1);
    do_flush(0);
    chk("t4_f0_pc", pc_out, 32'h100);
    chk("t4_f0_cnt", 32'(count), 32'd1);
    chk("t4_f0_id", 32'(ckpt_id), 32'd0);
    do_flush(2);
    chk("t4_finv_pc", pc_out, 32'h100);
    chk("t4_finv_cnt", 32'(count), 32'd1);
    chk("t4_finv_id", 32'(ckpt_id), 32'd0);

    // TOS repair after wrong-path pop+push
    do_push(32'h200);
    do_take();
    do_pop();
    do_push(32'h900);
    do_flush(0);
    chk("t5_cnt", 32'(count), 32'd2);
`ifdef RAS_TOS_REPAIR_EN
    chk("t5_pc", pc_out, 32'h200);
`else
    chk("t5_pc", pc_out, 32'h900);
`endif

    // Checkpoint queue limits
    do_take(); do_take(); do_take(); do_take();
    chk("t6_full", 32'(ckpt_full), 32'd1);
    do_take();
    chk("t6_ovf_full", 32'(ckpt_full), 32'd1);
    chk("t6_ovf_id", 32'(ckpt_id), 32'd0);
    cyc("tr", 0, 0, 0, 1, 1, 0, 0);
    chk("t6_tr_full", 32'(ckpt_full), 32'd0);
    chk("t6_tr_id", 32'(ckpt_id), 32'd0);
    cyc("tr2", 0, 0, 0, 1, 1, 0, 0);
    chk("t6_tr2_id", 32'(ckpt_id), 32'd1);
    cyc("res", 0, 0, 0, 0, 1, 0, 0);
    chk("t6_res_full", 32'(ckpt_full), 32'd0);
    do_push(32'h700);
    do_reset("t6");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit p, po, tk, rs, fl;
      p  = ($urandom_range(0, 9) < 4);
      po = ($urandom_range(0, 9) < 4);
      tk = ($urandom_range(0, 9) < 3);
      rs = ($urandom_range(0, 9) < 2);
      fl = ($urandom_range(0, 15) == 0);
      cyc("rnd", p, $urandom, po, tk, rs, fl, int'($urandom_range(0, D - 1)));
      if (i % 700 == 699) do_reset("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
